load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 37 +++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and memory-port bundle for the load/store unit
//   req_*  : core -> unit request handshake (valid/ready) with store flag, size, sign mode, byte address, store data
//   resp_* : unit -> core response handshake (valid/ready) with extended load data and error flag
//   mem_*  : unit -> memory word-addressed read port (combinational data) and write port
//   slave  : view taken by the unit; master : view taken by the core/memory side
interface load_store_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_is_store;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_error;
   logic [ADDR_WIDTH-1:0] mem_read_addr;
   logic                  mem_read_enable;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic [ADDR_WIDTH-1:0] mem_write_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write_enable;
   modport slave (
      input  req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_read_addr, mem_read_enable, mem_write_addr, mem_write_data, mem_write_enable
   );
   modport master (
      output req_valid, req_is_store, req_size, req_unsigned, req_addr, req_wdata, resp_ready, mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_read_addr, mem_read_enable, mem_write_addr, mem_write_data, mem_write_enable
   );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store engine over a word-wide memory
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory ports)
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   load_store_unit_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
   state_t                state_q, state_d;
   logic                  store_q, store_d;
   logic                  unsigned_q, unsigned_d;
   logic [1:0]            size_q, size_d;
   logic [1:0]            lane_q, lane_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  error_q, error_d;
   logic                  ready_q, ready_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic                  misaligned;
   logic [4:0]            sh;
   logic [DATA_WIDTH-1:0] shifted, extended, lane_mask, merged;
   assign bus.req_ready        = ready_q;
   assign bus.resp_valid       = rvalid_q;
   assign bus.resp_rdata       = rdata_q;
   assign bus.resp_error       = error_q;
   assign bus.mem_read_addr    = waddr_q;
   assign bus.mem_read_enable  = rd_en_q;
   assign bus.mem_write_addr   = waddr_q;
   assign bus.mem_write_data   = wdata_q;
   assign bus.mem_write_enable = wr_en_q;
   always_comb begin
      misaligned = bus.req_size == 2'b11 ||
                   (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                   (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
      sh        = {lane_q, 3'b000};
      shifted   = bus.mem_read_data >> sh;
      extended  = size_q == 2'b00 ? {{(DATA_WIDTH-8){~unsigned_q & shifted[7]}}, shifted[7:0]} :
                  size_q == 2'b01 ? {{(DATA_WIDTH-16){~unsigned_q & shifted[15]}}, shifted[15:0]} : shifted;
      lane_mask = (size_q == 2'b00 ? DATA_WIDTH'(8'hFF) : DATA_WIDTH'(16'hFFFF)) << sh;
      // read-modify-write: keep the old word outside the addressed lanes
      merged    = (bus.mem_read_data & ~lane_mask) | ((wdata_q << sh) & lane_mask);
   end
   always_comb begin
      state_d    = state_q;
      store_d    = store_q;
      unsigned_d = unsigned_q;
      size_d     = size_q;
      lane_d     = lane_q;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      error_d    = error_q;
      case (state_q)
         IDLE: if (bus.req_valid && ready_q) begin
            store_d    = bus.req_is_store;
            unsigned_d = bus.req_unsigned;
            size_d     = bus.req_size;
            lane_d     = bus.req_addr[1:0];
            waddr_d    = {2'b00, bus.req_addr[ADDR_WIDTH-1:2]};
            wdata_d    = bus.req_wdata;
            rdata_d    = '0;
            error_d    = misaligned;
            state_d    = misaligned ? RESP : (bus.req_is_store && bus.req_size == 2'b10) ? WRITE : READ;
         end
         READ: begin
            state_d = store_q ? WRITE : RESP;
            wdata_d = store_q ? merged : wdata_q;
            rdata_d = store_q ? rdata_q : extended;
         end
         WRITE: state_d = RESP;
         RESP: state_d = bus.resp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
      // outputs are registered: decode them from the next state
      ready_d  = state_d == IDLE;
      rvalid_d = state_d == RESP;
      rd_en_d  = state_d == READ;
      wr_en_d  = state_d == WRITE;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         store_q    <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'b00;
         lane_q     <= 2'b00;
         waddr_q    <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
         ready_q    <= 1'b1;
         rvalid_q   <= 1'b0;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         store_q    <= store_d;
         unsigned_q <= unsigned_d;
         size_q     <= size_d;
         lane_q     <= lane_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         error_q    <= error_d;
         ready_q    <= ready_d;
         rvalid_q   <= rvalid_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   logic [31:0] mem [0:255];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_a = 8'h00;
   logic [31:0] pre_d = 32'h0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] rd_addr = 32'h0;
   logic [31:0] wr_addr = 32'h0;
   int          n_vec = 0;
   int          n_bad = 0;
   assign bus.mem_read_data = mem[bus.mem_read_addr[7:0]];
   always @(posedge clk) begin
      if (pre_en) mem[pre_a] <= pre_d;
      if (bus.mem_read_enable) begin
         rd_cnt  <= rd_cnt + 1;
         rd_addr <= bus.mem_read_addr;
      end
      if (bus.mem_write_enable) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.mem_write_addr;
         mem[bus.mem_write_addr[7:0]] <= bus.mem_write_data;
      end
   end
   task automatic preload(input logic [7:0] a, input logic [31:0] d);
      pre_a  = a;
      pre_d  = d;
      pre_en = 1'b1;
      @(negedge clk);
      pre_en = 1'b0;
   endtask
   // issues one request from a negedge in IDLE, returns latency (99 on timeout) and response
   task automatic do_req(input logic st, input logic [1:0] sz, input logic un, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er);
      bus.req_valid    = 1'b1;
      bus.req_is_store = st;
      bus.req_size     = sz;
      bus.req_unsigned = un;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.resp_valid) lat = 99;
      rd = bus.resp_rdata;
      er = bus.resp_error;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask
   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
      n_vec++; if (bus.resp_error !== 1'b0) begin n_bad++; $display("FAIL rst_resp_error: got %b want 0", bus.resp_error); end
      n_vec++; if (bus.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
      n_vec++; if (bus.mem_read_enable !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b want 0", bus.mem_read_enable); end
      n_vec++; if (bus.mem_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_wr_en: got %b want 0", bus.mem_write_enable); end
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
   endtask
   task automatic test_loads();
      int lat; logic [31:0] rd; logic er; int r0, w0;
      logic [31:0] addrs [5] = '{32'h103, 32'h102, 32'h102, 32'h100, 32'h100};
      logic [1:0]  sizes [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
      logic        unss  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] exps  [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_1234, 32'h80FF_1234};
      preload(8'h40, 32'h80FF_1234);
      for (int i = 0; i < 5; i++) begin
         r0 = rd_cnt; w0 = wr_cnt;
         do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0, lat, rd, er);
         n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
         n_vec++; if (rd !== exps[i]) begin n_bad++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, exps[i]); end
         n_vec++; if (er !== 1'b0) begin n_bad++; $display("FAIL load%0d_error: got %b want 0", i, er); end
         n_vec++; if (rd_cnt - r0 !== 1 || wr_cnt !== w0) begin n_bad++; $display("FAIL load%0d_strobes: got rd %0d wr %0d want 1 0", i, rd_cnt - r0, wr_cnt - w0); end
         n_vec++; if (rd_addr !== 32'h40) begin n_bad++; $display("FAIL load%0d_rd_addr: got %h want 40", i, rd_addr); end
      end
   endtask
   task automatic test_subword_store();
      int lat; logic [31:0] rd; logic er; int r0, w0;
      preload(8'h40, 32'h1122_3344);
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, lat, rd, er);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sh_latency: got %0d want 3", lat); end
      n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_bad++; $display("FAIL sh_resp: got %h/%b want 0/0", rd, er); end
      n_vec++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sh_strobes: got rd %0d wr %0d want 1 1", rd_cnt - r0, wr_cnt - w0); end
      n_vec++; if (wr_addr !== 32'h40) begin n_bad++; $display("FAIL sh_wr_addr: got %h want 40", wr_addr); end
      n_vec++; if (mem[8'h40] !== 32'hBEEF_3344) begin n_bad++; $display("FAIL sh_mem: got %h want beef3344", mem[8'h40]); end
      do_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_56A5, lat, rd, er);
      n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
      n_vec++; if (mem[8'h40] !== 32'hBEEF_A544) begin n_bad++; $display("FAIL sb_mem: got %h want beefa544", mem[8'h40]); end
   endtask
   task automatic test_misaligned();
      int lat; logic [31:0] rd; logic er; int r0, w0;
      logic        sts   [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] addrs [3] = '{32'h06, 32'h101, 32'h100};
      for (int i = 0; i < 3; i++) begin
         r0 = rd_cnt; w0 = wr_cnt;
         do_req(sts[i], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, lat, rd, er);
         n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL err%0d_latency: got %0d want 1", i, lat); end
         n_vec++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err%0d_resp: got %b/%h want 1/0", i, er, rd); end
         n_vec++; if (rd_cnt !== r0 || wr_cnt !== w0) begin n_bad++; $display("FAIL err%0d_strobes: got rd %0d wr %0d want 0 0", i, rd_cnt - r0, wr_cnt - w0); end
      end
      n_vec++; if (mem[8'h40] !== 32'hBEEF_A544) begin n_bad++; $display("FAIL err_mem: got %h want beefa544", mem[8'h40]); end
   endtask
   task automatic test_stall();
      preload(8'h05, 32'hCAFE_F00D);
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h14;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      n_vec++; if (bus.resp_valid !== 1'b1) begin n_bad++; $display("FAIL stall_first: got %b want 1", bus.resp_valid); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hCAFE_F00D || bus.req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got v=%b d=%h rdy=%b want 1 cafef00d 0", i, bus.resp_valid, bus.resp_rdata, bus.req_ready);
         end
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      n_vec++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got rdy=%b v=%b want 1 0", bus.req_ready, bus.resp_valid); end
   endtask
   task automatic test_reset_mid();
      int w0;
      preload(8'h40, 32'h1122_3344);
      w0 = wr_cnt;
      bus.req_valid    = 1'b1;
      bus.req_is_store = 1'b1;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h100;
      bus.req_wdata    = 32'h0000_0099;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_vec++; if (bus.mem_read_enable !== 1'b1) begin n_bad++; $display("FAIL rmid_in_read: got %b want 1", bus.mem_read_enable); end
      reset = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.mem_write_enable !== 1'b0 || bus.mem_read_enable !== 1'b0 || bus.resp_valid !== 1'b0 ||
          bus.resp_error !== 1'b0 || bus.resp_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL rmid_outputs: got we=%b re=%b v=%b e=%b d=%h want all 0", bus.mem_write_enable,
                  bus.mem_read_enable, bus.resp_valid, bus.resp_error, bus.resp_rdata);
      end
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", bus.req_ready); end
      repeat (3) @(negedge clk);
      n_vec++; if (wr_cnt !== w0 || mem[8'h40] !== 32'h1122_3344) begin n_bad++; $display("FAIL rmid_no_write: got %0d writes mem %h want 0 11223344", wr_cnt - w0, mem[8'h40]); end
   endtask
   task automatic test_back_to_back();
      int lat; logic [31:0] rd; logic er; int r0, w0;
      r0 = rd_cnt; w0 = wr_cnt;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
      n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_st_latency: got %0d want 2", lat); end
      n_vec++; if (rd_cnt !== r0 || wr_cnt - w0 !== 1 || wr_addr !== 32'h4) begin n_bad++; $display("FAIL b2b_st_strobes: got rd %0d wr %0d addr %h want 0 1 4", rd_cnt - r0, wr_cnt - w0, wr_addr); end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er);
      n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL b2b_ld_latency: got %0d want 2", lat); end
      n_vec++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_bad++; $display("FAIL b2b_ld_rdata: got %h/%b want deadbeef/0", rd, er); end
   endtask
   initial begin
      bus.req_valid    = 1'b0;
      bus.req_is_store = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.resp_ready   = 1'b0;
      test_reset();
      test_loads();
      test_subword_store();
      test_misaligned();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
